// File: rtl/axi_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// axi_ctrl_pkg
// Shared definitions for the AXI4-Lite control slave of the blur accelerator:
// register byte addresses, AXI response codes, write/read FSM encodings and
// small helpers used by the register-file decode.
// ---------------------------------------------------------------------------
package axi_ctrl_pkg;

    // Register byte addresses (only bits [7:0] of the AXI address matter)
    localparam logic [7:0] ADDR_CTRL   = 8'h00;
    localparam logic [7:0] ADDR_STATUS = 8'h04;
    localparam logic [7:0] ADDR_ENABLE = 8'h40;
    localparam logic [7:0] ADDR_WEIGHT = 8'h44;

    // AXI response codes
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Write channel sequencing: address, then data, then response
    typedef enum logic [1:0] {
        W_ADDR = 2'd0,
        W_DATA = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    // Read channel sequencing: address, then data
    typedef enum logic {
        R_ADDR = 1'b0,
        R_DATA = 1'b1
    } rd_state_e;

    // Merge new write data into an existing word, one byte lane per strobe bit
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        for (int b = 0; b < 4; b++) begin
            merged[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        end
        return merged;
    endfunction

    // Byte address of WEIGHT register number idx
    function automatic logic [7:0] weight_addr(input int idx);
        return ADDR_WEIGHT + 8'(idx * 4);
    endfunction

endpackage

// File: rtl/axi_lite_ctrl_slave.sv
// ---------------------------------------------------------------------------
// axi_lite_ctrl_slave
// AXI4-Lite responder owning the accelerator control register file:
// CTRL (start W1S / done W1C), STATUS (idle + completed-run counter),
// ENABLE and NUM_WEIGHTS byte-maskable WEIGHT words.
//
// Ports
//   clk, reset                 sole clock; asynchronous active-high reset
//   AW*/W*/B*                  AXI-Lite write address / data / response
//   AR*/R*                     AXI-Lite read address / data
//   ap_start                   run request to the blur core (CTRL.start)
//   ap_done, ap_idle           completion pulse and idle level from the core
//   enable                     ENABLE[0]
//   weights                    weight i at [i*WEIGHT_W +: WEIGHT_W]
// ---------------------------------------------------------------------------
module axi_lite_ctrl_slave
    import axi_ctrl_pkg::*;
#(
    parameter int NUM_WEIGHTS = 10,
    parameter int WEIGHT_W    = 16,
    parameter int ADDR_W      = 32
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [ADDR_W-1:0]               AWADDR,
    input  logic                            AWVALID,
    output logic                            AWREADY,
    input  logic [31:0]                     WDATA,
    input  logic [3:0]                      WSTRB,
    input  logic                            WVALID,
    output logic                            WREADY,
    output logic [1:0]                      BRESP,
    output logic                            BVALID,
    input  logic                            BREADY,
    input  logic [ADDR_W-1:0]               ARADDR,
    input  logic                            ARVALID,
    output logic                            ARREADY,
    output logic [31:0]                     RDATA,
    output logic [1:0]                      RRESP,
    output logic                            RVALID,
    input  logic                            RREADY,
    output logic                            ap_start,
    input  logic                            ap_done,
    input  logic                            ap_idle,
    output logic                            enable,
    output logic [NUM_WEIGHTS*WEIGHT_W-1:0] weights
);

    wr_state_e   wr_state_q, wr_state_d;
    rd_state_e   rd_state_q, rd_state_d;
    logic [7:0]  aw_addr_q, aw_addr_d;
    logic [1:0]  bresp_q, bresp_d;
    logic [1:0]  rresp_q, rresp_d;
    logic [31:0] rdata_q, rdata_d;
    logic        start_q, start_d;
    logic        done_q, done_d;
    logic        enable_q, enable_d;
    logic [15:0] run_cnt_q, run_cnt_d;
    logic [31:0] weight_q [NUM_WEIGHTS];
    logic [31:0] weight_d [NUM_WEIGHTS];

    logic        wr_commit;
    logic        wr_mapped;
    logic        wr_ctrl;
    logic [7:0]  ar_addr;
    logic        rd_mapped;
    logic [31:0] rd_value;
    logic        unused_addr_bits;

    // Only address bits [7:2] select a register; the rest are don't-care
    assign unused_addr_bits = ^{AWADDR[ADDR_W-1:8], AWADDR[1:0],
                                ARADDR[ADDR_W-1:8], ARADDR[1:0]};
    assign ar_addr = {ARADDR[7:2], 2'b00};

    // Handshake outputs come straight from the state registers so no
    // VALID/READY input ever reaches a VALID/READY output combinationally
    assign AWREADY  = (wr_state_q == W_ADDR);
    assign WREADY   = (wr_state_q == W_DATA);
    assign BVALID   = (wr_state_q == W_RESP);
    assign ARREADY  = (rd_state_q == R_ADDR);
    assign RVALID   = (rd_state_q == R_DATA);
    assign BRESP    = bresp_q;
    assign RRESP    = rresp_q;
    assign RDATA    = rdata_q;
    assign ap_start = start_q;
    assign enable   = enable_q;

    // Decode whether the latched write address hits a mapped register
    always_comb begin
        wr_mapped = (aw_addr_q == ADDR_CTRL) || (aw_addr_q == ADDR_STATUS) ||
                    (aw_addr_q == ADDR_ENABLE);
        for (int i = 0; i < NUM_WEIGHTS; i++) begin
            if (aw_addr_q == weight_addr(i)) wr_mapped = 1'b1;
        end
    end

    // Write FSM: latch address, commit on the data beat, hold the response
    // until the master takes it
    always_comb begin
        wr_state_d = wr_state_q;
        aw_addr_d  = aw_addr_q;
        bresp_d    = bresp_q;
        wr_commit  = 1'b0;
        case (wr_state_q)
            W_ADDR: begin
                if (AWVALID) begin
                    aw_addr_d  = {AWADDR[7:2], 2'b00};
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (WVALID) begin
                    wr_commit  = 1'b1;
                    bresp_d    = wr_mapped ? RESP_OKAY : RESP_SLVERR;
                    wr_state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (BREADY) wr_state_d = W_ADDR;
            end
            default: wr_state_d = W_ADDR;
        endcase
    end

    // Register file update. Order matters: clearing done loses to a new
    // completion pulse, and a fresh start request beats the pulse's clear
    always_comb begin
        start_d   = start_q;
        done_d    = done_q;
        enable_d  = enable_q;
        run_cnt_d = run_cnt_q;
        weight_d  = weight_q;
        wr_ctrl   = wr_commit && (aw_addr_q == ADDR_CTRL) && WSTRB[0];

        if (wr_ctrl && WDATA[1]) done_d = 1'b0;
        if (ap_done) begin
            done_d    = 1'b1;
            start_d   = 1'b0;
            run_cnt_d = run_cnt_q + 16'd1;
        end
        if (wr_ctrl && WDATA[0]) start_d = 1'b1;

        if (wr_commit && (aw_addr_q == ADDR_ENABLE) && WSTRB[0]) enable_d = WDATA[0];

        for (int i = 0; i < NUM_WEIGHTS; i++) begin
            if (wr_commit && (aw_addr_q == weight_addr(i))) begin
                weight_d[i] = apply_wstrb(weight_q[i], WDATA, WSTRB);
            end
        end
    end

    // Read mux over the current register contents; unmapped reads give 0
    always_comb begin
        rd_value  = 32'd0;
        rd_mapped = 1'b1;
        case (ar_addr)
            ADDR_CTRL:   rd_value = {30'd0, done_q, start_q};
            ADDR_STATUS: rd_value = {run_cnt_q, 15'd0, ap_idle};
            ADDR_ENABLE: rd_value = {31'd0, enable_q};
            default:     rd_mapped = 1'b0;
        endcase
        for (int i = 0; i < NUM_WEIGHTS; i++) begin
            if (ar_addr == weight_addr(i)) begin
                rd_mapped = 1'b1;
                rd_value  = weight_q[i];
            end
        end
    end

    // Read FSM: capture data and response at the address handshake, using
    // pre-update register values, then hold them until RREADY
    always_comb begin
        rd_state_d = rd_state_q;
        rdata_d    = rdata_q;
        rresp_d    = rresp_q;
        case (rd_state_q)
            R_ADDR: begin
                if (ARVALID) begin
                    rdata_d    = rd_value;
                    rresp_d    = rd_mapped ? RESP_OKAY : RESP_SLVERR;
                    rd_state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (RREADY) rd_state_d = R_ADDR;
            end
            default: rd_state_d = R_ADDR;
        endcase
    end

    // Drive the low WEIGHT_W bits of each weight register onto the core bus
    always_comb begin
        weights = '0;
        for (int i = 0; i < NUM_WEIGHTS; i++) begin
            weights[i*WEIGHT_W +: WEIGHT_W] = weight_q[i][WEIGHT_W-1:0];
        end
    end

    // All state; reset drops any pending response and returns both FSMs idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_state_q <= W_ADDR;
            rd_state_q <= R_ADDR;
            aw_addr_q  <= 8'd0;
            bresp_q    <= RESP_OKAY;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= 32'd0;
            start_q    <= 1'b0;
            done_q     <= 1'b0;
            enable_q   <= 1'b0;
            run_cnt_q  <= 16'd0;
            for (int i = 0; i < NUM_WEIGHTS; i++) weight_q[i] <= 32'd0;
        end else begin
            wr_state_q <= wr_state_d;
            rd_state_q <= rd_state_d;
            aw_addr_q  <= aw_addr_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            start_q    <= start_d;
            done_q     <= done_d;
            enable_q   <= enable_d;
            run_cnt_q  <= run_cnt_d;
            for (int i = 0; i < NUM_WEIGHTS; i++) weight_q[i] <= weight_d[i];
        end
    end

endmodule

// File: tb/tb_axi_lite_ctrl_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_ctrl_slave
// Self-checking bench for axi_lite_ctrl_slave: directed register-map cases
// followed by randomized AXI-Lite traffic, all compared against a
// register-level model of the control block.
// ---------------------------------------------------------------------------
module tb_axi_lite_ctrl_slave;

    localparam int NW = 10;
    localparam int WW = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [31:0]       AWADDR = '0;
    logic              AWVALID = 1'b0;
    logic              AWREADY;
    logic [31:0]       WDATA = '0;
    logic [3:0]        WSTRB = '0;
    logic              WVALID = 1'b0;
    logic              WREADY;
    logic [1:0]        BRESP;
    logic              BVALID;
    logic              BREADY = 1'b0;
    logic [31:0]       ARADDR = '0;
    logic              ARVALID = 1'b0;
    logic              ARREADY;
    logic [31:0]       RDATA;
    logic [1:0]        RRESP;
    logic              RVALID;
    logic              RREADY = 1'b0;
    logic              ap_start;
    logic              ap_done = 1'b0;
    logic              ap_idle = 1'b1;
    logic              enable;
    logic [NW*WW-1:0]  weights;

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    // Register-level model of the control block
    logic        m_start, m_done, m_enable;
    logic [15:0] m_count;
    logic [31:0] m_weight [NW];

    axi_lite_ctrl_slave #(.NUM_WEIGHTS(NW), .WEIGHT_W(WW), .ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .ap_start(ap_start), .ap_done(ap_done), .ap_idle(ap_idle),
        .enable(enable), .weights(weights)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string name, input logic [159:0] act, input logic [159:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void modelReset();
        m_start = 1'b0;
        m_done = 1'b0;
        m_enable = 1'b0;
        m_count = 16'd0;
        for (int i = 0; i < NW; i++) m_weight[i] = 32'd0;
    endfunction

    // One clock edge of the register map: optional write plus optional done pulse
    function automatic void modelStep(input logic do_write, input logic [31:0] addr,
                                      input logic [31:0] data, input logic [3:0] strb,
                                      input logic done, output logic [1:0] resp);
        logic [7:0] a;
        logic set_start, clr_done;
        int idx;
        a = addr[7:0] & 8'hFC;
        set_start = 1'b0;
        clr_done = 1'b0;
        resp = 2'b00;
        if (do_write) begin
            if (a == 8'h00) begin
                if (strb[0]) begin
                    set_start = data[0];
                    clr_done = data[1];
                end
            end else if (a == 8'h04) begin
                resp = 2'b00;
            end else if (a == 8'h40) begin
                if (strb[0]) m_enable = data[0];
            end else if (a >= 8'h44 && a < 8'h44 + 8'(4 * NW)) begin
                idx = (int'(a) - 68) / 4;
                for (int b = 0; b < 4; b++) begin
                    if (strb[b]) m_weight[idx][8*b +: 8] = data[8*b +: 8];
                end
            end else begin
                resp = 2'b10;
            end
        end
        if (done) begin
            m_done = 1'b1;
            m_count = m_count + 16'd1;
        end else if (clr_done) begin
            m_done = 1'b0;
        end
        if (set_start) m_start = 1'b1;
        else if (done) m_start = 1'b0;
    endfunction

    function automatic void expectedRead(input logic [31:0] addr, output logic [31:0] data,
                                         output logic [1:0] resp);
        logic [7:0] a;
        a = addr[7:0] & 8'hFC;
        data = 32'd0;
        resp = 2'b00;
        if (a == 8'h00) data = {30'd0, m_done, m_start};
        else if (a == 8'h04) data = {m_count, 15'd0, ap_idle};
        else if (a == 8'h40) data = {31'd0, m_enable};
        else if (a >= 8'h44 && a < 8'h44 + 8'(4 * NW)) data = m_weight[(int'(a) - 68) / 4];
        else resp = 2'b10;
    endfunction

    function automatic logic [NW*WW-1:0] modelWeights();
        logic [NW*WW-1:0] r;
        for (int i = 0; i < NW; i++) r[i*WW +: WW] = m_weight[i][WW-1:0];
        return r;
    endfunction

    // Continuous check of the core-facing outputs every cycle
    always @(negedge clk) begin
        if (check_en) begin
            checkOutput("ap_start", ap_start, m_start);
            checkOutput("enable", enable, m_enable);
            checkOutput("weights", weights, modelWeights());
        end
    end

    function automatic logic sel(input int w);
        case (w)
            0: return AWREADY;
            1: return WREADY;
            2: return BVALID;
            3: return ARREADY;
            default: return RVALID;
        endcase
    endfunction

    // Bounded wait, sampled at negedges; an expired bound shows as a miscompare
    task automatic waitSig(input int w, input string name);
        int n = 0;
        while (sel(w) !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput(name, sel(w), 1'b1);
    endtask

    task automatic writeAddrData(input logic [31:0] addr, input logic [31:0] data,
                                 input logic [3:0] strb, input logic done,
                                 output logic [1:0] exp_resp);
        @(negedge clk);
        AWADDR = addr;
        AWVALID = 1'b1;
        waitSig(0, "awready");
        @(posedge clk);
        #1;
        AWVALID = 1'b0;
        WDATA = data;
        WSTRB = strb;
        WVALID = 1'b1;
        @(negedge clk);
        checkOutput("wready_latency", WREADY, 1'b1);
        waitSig(1, "wready");
        ap_done = done;
        @(posedge clk);
        #1;
        WVALID = 1'b0;
        ap_done = 1'b0;
        modelStep(1'b1, addr, data, strb, done, exp_resp);
    endtask

    task automatic writeResp(input logic [1:0] exp_resp, input int hold, output logic [1:0] got);
        @(negedge clk);
        checkOutput("bvalid_latency", BVALID, 1'b1);
        checkOutput("bresp", BRESP, exp_resp);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            checkOutput("bvalid_hold", BVALID, 1'b1);
            checkOutput("bresp_hold", BRESP, exp_resp);
            checkOutput("awready_blocked", AWREADY, 1'b0);
        end
        got = BRESP;
        BREADY = 1'b1;
        @(posedge clk);
        #1;
        BREADY = 1'b0;
        @(negedge clk);
        checkOutput("bvalid_clear", BVALID, 1'b0);
        checkOutput("awready_back", AWREADY, 1'b1);
    endtask

    task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic done, input int hold,
                            output logic [1:0] got);
        logic [1:0] er;
        writeAddrData(addr, data, strb, done, er);
        writeResp(er, hold, got);
    endtask

    task automatic readAddr(input logic [31:0] addr, output logic [31:0] exp_data,
                            output logic [1:0] exp_resp);
        @(negedge clk);
        ARADDR = addr;
        ARVALID = 1'b1;
        waitSig(3, "arready");
        expectedRead(addr, exp_data, exp_resp);
        @(posedge clk);
        #1;
        ARVALID = 1'b0;
    endtask

    task automatic readResp(input logic [31:0] exp_data, input logic [1:0] exp_resp,
                            input int hold, output logic [31:0] got, output logic [1:0] got_resp);
        @(negedge clk);
        checkOutput("rvalid_latency", RVALID, 1'b1);
        checkOutput("rdata", RDATA, exp_data);
        checkOutput("rresp", RRESP, exp_resp);
        for (int c = 0; c < hold; c++) begin
            @(negedge clk);
            checkOutput("rvalid_hold", RVALID, 1'b1);
            checkOutput("rdata_hold", RDATA, exp_data);
            checkOutput("rresp_hold", RRESP, exp_resp);
            checkOutput("arready_blocked", ARREADY, 1'b0);
        end
        got = RDATA;
        got_resp = RRESP;
        RREADY = 1'b1;
        @(posedge clk);
        #1;
        RREADY = 1'b0;
        @(negedge clk);
        checkOutput("rvalid_clear", RVALID, 1'b0);
    endtask

    task automatic axiRead(input logic [31:0] addr, input int hold,
                           output logic [31:0] got, output logic [1:0] got_resp);
        logic [31:0] ed;
        logic [1:0] er;
        readAddr(addr, ed, er);
        readResp(ed, er, hold, got, got_resp);
    endtask

    task automatic pulseDone();
        logic [1:0] dummy;
        @(negedge clk);
        ap_done = 1'b1;
        @(posedge clk);
        #1;
        ap_done = 1'b0;
        modelStep(1'b0, 32'd0, 32'd0, 4'd0, 1'b1, dummy);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_awready"}, AWREADY, 1'b1);
        checkOutput({tag, "_arready"}, ARREADY, 1'b1);
        checkOutput({tag, "_wready"}, WREADY, 1'b0);
        checkOutput({tag, "_bvalid"}, BVALID, 1'b0);
        checkOutput({tag, "_rvalid"}, RVALID, 1'b0);
        checkOutput({tag, "_bresp"}, BRESP, 2'b00);
        checkOutput({tag, "_rresp"}, RRESP, 2'b00);
        checkOutput({tag, "_rdata"}, RDATA, 32'd0);
        checkOutput({tag, "_ap_start"}, ap_start, 1'b0);
        checkOutput({tag, "_enable"}, enable, 1'b0);
        checkOutput({tag, "_weights"}, weights, 160'd0);
    endtask

    // Randomized traffic: writes (some with a coincident ap_done), reads and
    // bare completion pulses over mapped and unmapped addresses
    task automatic applyStimulus(input int count);
        for (int n = 0; n < count; n++) begin
            int op, r, hold;
            logic [31:0] hi, data, addr, got;
            logic [7:0] base;
            logic [3:0] strb;
            logic [1:0] lo, resp;
            logic done;
            op = $urandom_range(0, 9);
            r = $urandom_range(0, 15);
            hold = $urandom_range(0, 3);
            hi = $urandom();
            data = $urandom();
            strb = 4'($urandom_range(0, 15));
            lo = 2'($urandom_range(0, 3));
            done = ($urandom_range(0, 3) == 0);
            ap_idle = 1'($urandom_range(0, 1));
            case (r)
                0: base = 8'h00;
                1: base = 8'h04;
                2: base = 8'h40;
                13: base = 8'h80;
                14: base = 8'h3C;
                15: base = 8'($urandom_range(0, 255));
                default: base = 8'h44 + 8'(4 * (r - 3));
            endcase
            addr = {hi[31:8], base[7:2], lo};
            if (op <= 4) axiWrite(addr, data, strb, done, hold, resp);
            else if (op <= 8) axiRead(addr, hold, got, resp);
            else pulseDone();
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] d;
        logic [1:0] rr;
        logic [1:0] br;
        logic [31:0] lit [NW];
        lit = '{32'd1, 32'd3, 32'd3, 32'd15, 32'd6, 32'd25, 32'd3, 32'd15, 32'd1, 32'd3};

        modelReset();
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_en = 1'b1;
        @(negedge clk);
        checkResetValues("rst");

        // ENABLE and weight programming with read-back
        axiWrite(32'h40, 32'h1, 4'hF, 1'b0, 0, br);
        for (int i = 0; i < NW; i++) axiWrite(32'h44 + 32'(4 * i), lit[i], 4'hF, 1'b0, 0, br);
        for (int i = 0; i < NW; i++) begin
            axiRead(32'h44 + 32'(4 * i), 0, d, rr);
            checkOutput("weight_readback_lit", d, lit[i]);
            checkOutput("weight_rresp_lit", rr, 2'b00);
        end
        checkOutput("enable_lit", enable, 1'b1);
        checkOutput("weights_slice5_lit", weights[5*WW +: WW], 16'd25);

        // Start, completion and done clear
        axiWrite(32'h00, 32'h1, 4'hF, 1'b0, 0, br);
        checkOutput("ap_start_lit", ap_start, 1'b1);
        pulseDone();
        @(negedge clk);
        checkOutput("ap_start_cleared_lit", ap_start, 1'b0);
        ap_idle = 1'b1;
        axiRead(32'h00, 0, d, rr);
        checkOutput("ctrl_done_lit", d, 32'h2);
        axiRead(32'h04, 0, d, rr);
        checkOutput("status_lit", d, 32'h0001_0001);
        axiWrite(32'h00, 32'h2, 4'hF, 1'b0, 0, br);
        axiRead(32'h00, 0, d, rr);
        checkOutput("ctrl_cleared_lit", d, 32'h0);

        // Byte-masked weight write
        axiWrite(32'h4C, 32'hAABBCCDD, 4'hF, 1'b0, 0, br);
        axiWrite(32'h4C, 32'h11223344, 4'b0101, 1'b0, 0, br);
        axiRead(32'h4C, 0, d, rr);
        checkOutput("wstrb_merge_lit", d, 32'hAA22CC44);

        // Unmapped address
        axiWrite(32'h80, 32'hFFFFFFFF, 4'hF, 1'b0, 0, br);
        checkOutput("bresp_unmapped_lit", br, 2'b10);
        axiRead(32'h80, 0, d, rr);
        checkOutput("rresp_unmapped_lit", rr, 2'b10);
        checkOutput("rdata_unmapped_lit", d, 32'h0);

        // Back-pressure on both response channels
        axiWrite(32'h50, 32'hDEADBEEF, 4'hF, 1'b0, 5, br);
        axiRead(32'h50, 5, d, rr);
        checkOutput("held_read_lit", d, 32'hDEADBEEF);

        // ap_done coincident with W1C of done
        pulseDone();
        axiWrite(32'h00, 32'h2, 4'hF, 1'b1, 0, br);
        axiRead(32'h00, 0, d, rr);
        checkOutput("done_set_wins_lit", d, 32'h2);
        axiRead(32'h04, 0, d, rr);
        checkOutput("count_three_lit", d, 32'h0003_0001);

        applyStimulus(200);

        // Reset with both responses outstanding
        writeAddrData(32'h48, 32'h12345678, 4'hF, 1'b0, br);
        readAddr(32'h4C, d, rr);
        @(negedge clk);
        checkOutput("pending_bvalid", BVALID, 1'b1);
        checkOutput("pending_rvalid", RVALID, 1'b1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        modelReset();
        @(negedge clk);
        checkResetValues("mid_rst");
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checkResetValues("post_rst");
        axiRead(32'h48, 0, d, rr);
        checkOutput("weight_after_reset_lit", d, 32'h0);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
